// File: rtl/ibus_master.sv
// ibus initiator: sequences WRITE / READ / RUN commands onto a single-cycle ibus.
// Optional poll timeout for RUN is enabled by defining IBUS_MASTER_TIMEOUT_EN.
module ibus_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_adr,
    input  logic [9:0]  cmd_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [15:0] wd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [15:0] rd_data,
    output logic        wen,
    output logic [15:0] ibus_wadr,
    output logic [15:0] ibus_wdata,
    output logic        ren,
    output logic [15:0] ibus_radr,
    input  logic [15:0] ibus_rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WR         = 4'd1;
    localparam logic [3:0] S_RD         = 4'd2;
    localparam logic [3:0] S_RD_DRAIN   = 4'd3;
    localparam logic [3:0] S_RUN_MAX    = 4'd4;
    localparam logic [3:0] S_RUN_START  = 4'd5;
    localparam logic [3:0] S_POLL_ISSUE = 4'd6;
    localparam logic [3:0] S_POLL_WAIT  = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam logic [15:0] RUN_CTRL_ADR = 16'hFFF0;
    localparam logic [15:0] RUN_MAX_ADR  = 16'hFFF1;

    logic [3:0]  state_q, state_d;
    logic [15:0] adr_q, adr_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  runLen_q, runLen_d;
    logic        err_q, err_d;

    logic        pipe1_q, pipe2_q;
    logic [15:0] fifoMem_q [4];
    logic [1:0]  wrPtr_q, rdPtr_q;
    logic [2:0]  fifoCnt_q;

    logic [1:0]  outstanding;
    logic        issueOk;
    logic        rdIssue;
    logic        fifoPush;
    logic        fifoPop;

`ifdef IBUS_MASTER_TIMEOUT_EN
    logic [15:0] pollCnt_q;
`endif

    // A read may only be issued if its data is guaranteed a FIFO slot on arrival.
    assign outstanding = {1'b0, pipe1_q} + {1'b0, pipe2_q};
    assign issueOk     = ({1'b0, fifoCnt_q} + {2'b00, outstanding}) < 4'd4;
    assign rdIssue     = (state_q == S_RD) && issueOk;
    assign fifoPush    = pipe2_q;
    assign fifoPop     = rd_valid && rd_ready;

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        cnt_d    = cnt_q;
        runLen_d = runLen_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    adr_d    = cmd_adr;
                    cnt_d    = (cmd_len == 10'd0) ? 11'd1024 : {1'b0, cmd_len};
                    runLen_d = cmd_len[7:0];
                    err_d    = 1'b0;
                    case (cmd_op)
                        2'd0:    state_d = S_WR;
                        2'd1:    state_d = S_RD;
                        2'd2:    state_d = S_RUN_MAX;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_WR: begin
                if (wd_valid) begin
                    adr_d = adr_q + 16'd1;
                    cnt_d = cnt_q - 11'd1;
                    if (cnt_q == 11'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD: begin
                if (rdIssue) begin
                    adr_d = adr_q + 16'd1;
                    cnt_d = cnt_q - 11'd1;
                    if (cnt_q == 11'd1) begin
                        state_d = S_RD_DRAIN;
                    end
                end
            end
            S_RD_DRAIN: begin
                if (!pipe1_q && !pipe2_q && (fifoCnt_q == 3'd0)) begin
                    state_d = S_DONE;
                end
            end
            S_RUN_MAX:    state_d = S_RUN_START;
            S_RUN_START:  state_d = S_POLL_ISSUE;
            S_POLL_ISSUE: state_d = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (ibus_rdata[0]) begin
`ifdef IBUS_MASTER_TIMEOUT_EN
                    if (pollCnt_q == 16'hFFFF) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_POLL_ISSUE;
                    end
`else
                    state_d = S_POLL_ISSUE;
`endif
                end else begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            adr_q    <= 16'd0;
            cnt_q    <= 11'd0;
            runLen_q <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            cnt_q    <= cnt_d;
            runLen_q <= runLen_d;
            err_q    <= err_d;
        end
    end

    // Two-stage valid pipe models the fixed read latency; reset discards in-flight data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe1_q <= 1'b0;
            pipe2_q <= 1'b0;
        end else begin
            pipe1_q <= rdIssue;
            pipe2_q <= pipe1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifoMem_q[i] <= 16'd0;
            end
            wrPtr_q   <= 2'd0;
            rdPtr_q   <= 2'd0;
            fifoCnt_q <= 3'd0;
        end else begin
            if (fifoPush) begin
                fifoMem_q[wrPtr_q] <= ibus_rdata;
                wrPtr_q            <= wrPtr_q + 2'd1;
            end
            if (fifoPop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            case ({fifoPush, fifoPop})
                2'b10:   fifoCnt_q <= fifoCnt_q + 3'd1;
                2'b01:   fifoCnt_q <= fifoCnt_q - 3'd1;
                default: fifoCnt_q <= fifoCnt_q;
            endcase
        end
    end

`ifdef IBUS_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pollCnt_q <= 16'd0;
        end else if (state_q == S_RUN_MAX) begin
            pollCnt_q <= 16'd0;
        end else if (state_q == S_POLL_ISSUE) begin
            pollCnt_q <= pollCnt_q + 16'd1;
        end
    end
`endif

    // Bus address/data are forced to zero whenever the matching enable is low.
    always_comb begin
        wen        = 1'b0;
        ibus_wadr  = 16'd0;
        ibus_wdata = 16'd0;
        ren        = 1'b0;
        ibus_radr  = 16'd0;
        wd_ready   = 1'b0;
        case (state_q)
            S_WR: begin
                wd_ready = 1'b1;
                if (wd_valid) begin
                    wen        = 1'b1;
                    ibus_wadr  = adr_q;
                    ibus_wdata = wd_data;
                end
            end
            S_RD: begin
                if (rdIssue) begin
                    ren       = 1'b1;
                    ibus_radr = adr_q;
                end
            end
            S_RUN_MAX: begin
                wen        = 1'b1;
                ibus_wadr  = RUN_MAX_ADR;
                ibus_wdata = {8'd0, runLen_q};
            end
            S_RUN_START: begin
                wen        = 1'b1;
                ibus_wadr  = RUN_CTRL_ADR;
                ibus_wdata = 16'h0001;
            end
            S_POLL_ISSUE: begin
                ren       = 1'b1;
                ibus_radr = RUN_CTRL_ADR;
            end
            default: begin
                wen = 1'b0;
            end
        endcase
    end

    // cmd_ready is gated by rst_n so every output reads zero while reset is held.
    assign cmd_ready = rst_n && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_DONE) && err_q;
    assign rd_valid  = (fifoCnt_q != 3'd0);
    assign rd_data   = rd_valid ? fifoMem_q[rdPtr_q] : 16'd0;

endmodule

// File: tb/tb_ibus_master.sv
// Directed self-checking bench for ibus_master with a simple ibus slave model.
module tb_ibus_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_adr;
    logic [9:0]  cmd_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [15:0] wd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        wen;
    logic [15:0] ibus_wadr;
    logic [15:0] ibus_wdata;
    logic        ren;
    logic [15:0] ibus_radr;
    logic [15:0] ibus_rdata;
    logic        busy;
    logic        done;
    logic        err;

    int nAsserts = 0;
    int nFails   = 0;

    logic        pollMode    = 1'b0;
    logic        stuckOne    = 1'b0;
    logic        s1v         = 1'b0;
    logic        s2v         = 1'b0;
    logic [15:0] s1a         = 16'd0;
    logic [15:0] s2a         = 16'd0;
    logic [15:0] statusLatch = 16'd0;
    int          pollIdx     = 0;
    int          pollBase    = 0;

    ibus_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata),
        .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status sequence for RUN polls: bit0 set, bit0 set, bit0 clear (upper bits are noise).
    function automatic logic [15:0] statusFor(input int k);
        case (k)
            0:       return 16'h0003;
            1:       return 16'h0001;
            2:       return 16'h0002;
            default: return 16'h0000;
        endcase
    endfunction

    // Slave: memory reads return data two cycles after ren, status polls one cycle after.
    always @(posedge clk) begin
        s1v <= ren;
        s1a <= ibus_radr;
        s2v <= s1v;
        s2a <= s1a;
        if (ren && pollMode) begin
            pollIdx     <= pollIdx + 1;
            statusLatch <= stuckOne ? 16'h0001 : statusFor(pollIdx - pollBase);
        end
    end

    assign ibus_rdata = pollMode ? (s1v ? statusLatch : 16'hFFFF)
                                 : (s2v ? (s2a ^ 16'h5A5A) : 16'hBAD0);

    task automatic sendCmd(input logic [1:0] op, input logic [15:0] adr, input logic [9:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_adr   = adr;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_adr   = 16'd0;
        cmd_len   = 10'd0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        nAsserts++; if (cmd_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
        nAsserts++; if ({busy, done, err, wen, ren, rd_valid, wd_ready} !== 7'b0) begin nFails++; $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {busy, done, err, wen, ren, rd_valid, wd_ready}); end
        nAsserts++; if ({ibus_wadr, ibus_wdata, ibus_radr, rd_data} !== 64'd0) begin nFails++; $display("[TB] FAIL reset_buses: got %h expected 0", {ibus_wadr, ibus_wdata, ibus_radr, rd_data}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nAsserts++; if (cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL release_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_write();
        logic [15:0] dat [4];
        logic [15:0] expAdr [4];
        logic        vld [4];
        $display("[TB] test_write");
        dat    = '{16'h1111, 16'h9999, 16'h2222, 16'h3333};
        expAdr = '{16'h0400, 16'h0000, 16'h0401, 16'h0402};
        vld    = '{1'b1, 1'b0, 1'b1, 1'b1};
        @(negedge clk); #1;
        nAsserts++; if (cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL wr_idle_ready: got %b expected 1", cmd_ready); end
        sendCmd(2'd0, 16'h0400, 10'd3);
        for (int i = 0; i < 4; i++) begin
            wd_valid = vld[i];
            wd_data  = dat[i];
            #1;
            nAsserts++; if (wd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL wr_wd_ready[%0d]: got %b expected 1", i, wd_ready); end
            nAsserts++; if (wen !== vld[i]) begin nFails++; $display("[TB] FAIL wr_wen[%0d]: got %b expected %b", i, wen, vld[i]); end
            nAsserts++; if (ibus_wadr !== expAdr[i]) begin nFails++; $display("[TB] FAIL wr_adr[%0d]: got %h expected %h", i, ibus_wadr, expAdr[i]); end
            nAsserts++; if (ibus_wdata !== (vld[i] ? dat[i] : 16'h0000)) begin nFails++; $display("[TB] FAIL wr_data[%0d]: got %h expected %h", i, ibus_wdata, vld[i] ? dat[i] : 16'h0000); end
            nAsserts++; if ({ren, done} !== 2'b00) begin nFails++; $display("[TB] FAIL wr_ren_done[%0d]: got %b expected 00", i, {ren, done}); end
            @(negedge clk);
        end
        wd_valid = 1'b0;
        wd_data  = 16'h0000;
        #1;
        nAsserts++; if ({done, err} !== 2'b10) begin nFails++; $display("[TB] FAIL wr_done: got %b expected 10", {done, err}); end
        nAsserts++; if ({wen, wd_ready, busy} !== 3'b001) begin nFails++; $display("[TB] FAIL wr_done_state: got %b expected 001", {wen, wd_ready, busy}); end
        @(negedge clk); #1;
        nAsserts++; if ({cmd_ready, done, busy} !== 3'b100) begin nFails++; $display("[TB] FAIL wr_back_idle: got %b expected 100", {cmd_ready, done, busy}); end
    endtask

    task automatic test_wrap();
        logic [15:0] dat [2];
        logic [15:0] expAdr [2];
        $display("[TB] test_wrap");
        dat    = '{16'hAAAA, 16'hBBBB};
        expAdr = '{16'hFFFF, 16'h0000};
        @(negedge clk);
        sendCmd(2'd0, 16'hFFFF, 10'd2);
        for (int i = 0; i < 2; i++) begin
            wd_valid = 1'b1;
            wd_data  = dat[i];
            #1;
            nAsserts++; if ({wen, ibus_wadr, ibus_wdata} !== {1'b1, expAdr[i], dat[i]}) begin nFails++; $display("[TB] FAIL wrap_beat[%0d]: got %b/%h/%h expected 1/%h/%h", i, wen, ibus_wadr, ibus_wdata, expAdr[i], dat[i]); end
            @(negedge clk);
        end
        wd_valid = 1'b0;
        #1;
        nAsserts++; if ({done, err, wen} !== 3'b100) begin nFails++; $display("[TB] FAIL wrap_done: got %b expected 100", {done, err, wen}); end
    endtask

    task automatic test_read();
        int          issued = 0;
        int          popped = 0;
        int          maxOcc = 0;
        int          badWen = 0;
        logic        doneSeen = 1'b0;
        logic        errSeen  = 1'b0;
        logic [15:0] expA;
        $display("[TB] test_read");
        pollMode = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk); #1;
        nAsserts++; if (cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rd_idle_ready: got %b expected 1", cmd_ready); end
        sendCmd(2'd1, 16'h4000, 10'd6);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ren) begin
                expA = 16'h4000 + 16'(issued);
                nAsserts++; if (ibus_radr !== expA) begin nFails++; $display("[TB] FAIL rd_adr_hold: got %h expected %h", ibus_radr, expA); end
                issued++;
            end
            if (wen || done) badWen++;
            if (issued - popped > maxOcc) maxOcc = issued - popped;
            @(negedge clk);
        end
        nAsserts++; if (issued !== 4) begin nFails++; $display("[TB] FAIL rd_issued_while_stalled: got %0d expected 4", issued); end
        nAsserts++; if (rd_valid !== 1'b1) begin nFails++; $display("[TB] FAIL rd_valid_stalled: got %b expected 1", rd_valid); end
        rd_ready = 1'b1;
        for (int c = 0; c < 80 && !doneSeen; c++) begin
            #1;
            if (ren) begin
                expA = 16'h4000 + 16'(issued);
                nAsserts++; if (ibus_radr !== expA) begin nFails++; $display("[TB] FAIL rd_adr: got %h expected %h", ibus_radr, expA); end
                issued++;
            end
            if (wen) badWen++;
            if (issued - popped > maxOcc) maxOcc = issued - popped;
            if (rd_valid) begin
                expA = (16'h4000 + 16'(popped)) ^ 16'h5A5A;
                nAsserts++; if (rd_data !== expA) begin nFails++; $display("[TB] FAIL rd_data[%0d]: got %h expected %h", popped, rd_data, expA); end
                popped++;
            end
            if (done) begin
                doneSeen = 1'b1;
                errSeen  = err;
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        nAsserts++; if (doneSeen !== 1'b1) begin nFails++; $display("[TB] FAIL rd_done_timeout: got %b expected 1", doneSeen); end
        nAsserts++; if (errSeen !== 1'b0) begin nFails++; $display("[TB] FAIL rd_err: got %b expected 0", errSeen); end
        nAsserts++; if (issued !== 6 || popped !== 6) begin nFails++; $display("[TB] FAIL rd_counts: got issued %0d popped %0d expected 6 6", issued, popped); end
        nAsserts++; if (maxOcc > 4) begin nFails++; $display("[TB] FAIL rd_occupancy: got %0d expected <=4", maxOcc); end
        nAsserts++; if (badWen !== 0) begin nFails++; $display("[TB] FAIL rd_no_wen: got %0d expected 0", badWen); end
        #1;
        nAsserts++; if (cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rd_back_idle: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_run();
        int   polls = 0;
        int   badWen = 0;
        logic doneSeen = 1'b0;
        logic errSeen  = 1'b0;
        $display("[TB] test_run");
        pollMode = 1'b1;
        stuckOne = 1'b0;
        pollBase = pollIdx;
        @(negedge clk);
        sendCmd(2'd2, 16'h1234, 10'h010);
        #1;
        nAsserts++; if ({wen, ren, ibus_wadr, ibus_wdata} !== {2'b10, 16'hFFF1, 16'h0010}) begin nFails++; $display("[TB] FAIL run_max: got %b%b/%h/%h expected 10/fff1/0010", wen, ren, ibus_wadr, ibus_wdata); end
        @(negedge clk); #1;
        nAsserts++; if ({wen, ren, ibus_wadr, ibus_wdata} !== {2'b10, 16'hFFF0, 16'h0001}) begin nFails++; $display("[TB] FAIL run_start: got %b%b/%h/%h expected 10/fff0/0001", wen, ren, ibus_wadr, ibus_wdata); end
        @(negedge clk);
        for (int c = 0; c < 40 && !doneSeen; c++) begin
            #1;
            if (ren) begin
                nAsserts++; if (ibus_radr !== 16'hFFF0) begin nFails++; $display("[TB] FAIL run_poll_adr: got %h expected fff0", ibus_radr); end
                polls++;
            end
            if (wen) badWen++;
            if (done) begin
                doneSeen = 1'b1;
                errSeen  = err;
            end
            @(negedge clk);
        end
        nAsserts++; if (doneSeen !== 1'b1) begin nFails++; $display("[TB] FAIL run_done_timeout: got %b expected 1", doneSeen); end
        nAsserts++; if (polls !== 3) begin nFails++; $display("[TB] FAIL run_polls: got %0d expected 3", polls); end
        nAsserts++; if (errSeen !== 1'b0) begin nFails++; $display("[TB] FAIL run_err: got %b expected 0", errSeen); end
        nAsserts++; if (badWen !== 0) begin nFails++; $display("[TB] FAIL run_no_wen_polling: got %0d expected 0", badWen); end
        pollMode = 1'b0;
    endtask

    task automatic test_illegal();
        $display("[TB] test_illegal");
        @(negedge clk); #1;
        nAsserts++; if (cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL ill_idle_ready: got %b expected 1", cmd_ready); end
        sendCmd(2'd3, 16'h1234, 10'd5);
        #1;
        nAsserts++; if ({done, err} !== 2'b11) begin nFails++; $display("[TB] FAIL ill_done_err: got %b expected 11", {done, err}); end
        nAsserts++; if ({wen, ren, wd_ready, cmd_ready} !== 4'b0000) begin nFails++; $display("[TB] FAIL ill_no_bus: got %b expected 0000", {wen, ren, wd_ready, cmd_ready}); end
        @(negedge clk); #1;
        nAsserts++; if ({cmd_ready, done, err} !== 3'b100) begin nFails++; $display("[TB] FAIL ill_back_idle: got %b expected 100", {cmd_ready, done, err}); end
    endtask

    task automatic test_reset_mid_read();
        int bad = 0;
        $display("[TB] test_reset_mid_read");
        pollMode = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        sendCmd(2'd1, 16'h2000, 10'd8);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        nAsserts++; if ({busy, rd_valid} !== 2'b11) begin nFails++; $display("[TB] FAIL mid_read_active: got %b expected 11", {busy, rd_valid}); end
        rst_n = 1'b0;
        #1;
        nAsserts++; if ({cmd_ready, busy, done, err, wen, ren, rd_valid, wd_ready} !== 8'b0) begin nFails++; $display("[TB] FAIL mid_reset_ctrl: got %b expected 00000000", {cmd_ready, busy, done, err, wen, ren, rd_valid, wd_ready}); end
        nAsserts++; if ({ibus_radr, rd_data} !== 32'd0) begin nFails++; $display("[TB] FAIL mid_reset_buses: got %h expected 0", {ibus_radr, rd_data}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nAsserts++; if (cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL mid_release_ready: got %b expected 1", cmd_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (rd_valid || done || busy) bad++;
        end
        nAsserts++; if (bad !== 0) begin nFails++; $display("[TB] FAIL mid_discard: got %0d bad cycles expected 0", bad); end
    endtask

`ifdef IBUS_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int   polls = 0;
        logic doneSeen = 1'b0;
        logic errSeen  = 1'b0;
        $display("[TB] test_timeout");
        pollMode = 1'b1;
        stuckOne = 1'b1;
        @(negedge clk);
        sendCmd(2'd2, 16'h0000, 10'h0FF);
        for (int c = 0; c < 140000 && !doneSeen; c++) begin
            #1;
            if (ren) polls++;
            if (done) begin
                doneSeen = 1'b1;
                errSeen  = err;
            end
            @(negedge clk);
        end
        nAsserts++; if (doneSeen !== 1'b1) begin nFails++; $display("[TB] FAIL to_done_timeout: got %b expected 1", doneSeen); end
        nAsserts++; if (polls !== 65535) begin nFails++; $display("[TB] FAIL to_polls: got %0d expected 65535", polls); end
        nAsserts++; if (errSeen !== 1'b1) begin nFails++; $display("[TB] FAIL to_err: got %b expected 1", errSeen); end
        pollMode = 1'b0;
        stuckOne = 1'b0;
    endtask
`endif

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_adr   = 16'd0;
        cmd_len   = 10'd0;
        wd_valid  = 1'b0;
        wd_data   = 16'd0;
        rd_ready  = 1'b0;
        test_reset();
        test_write();
        test_wrap();
        test_read();
        test_run();
        test_illegal();
        test_reset_mid_read();
`ifdef IBUS_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
